// File: rtl/servo_pkg.sv
// Shared constants and state encoding for the servo pulse generator/decoder pair.
package servo_pkg;

    localparam int unsigned DEF_MIN_WIDTH = 25000;
    localparam int unsigned DEF_MAX_WIDTH = 125000;
    localparam int unsigned DEF_TIMEOUT   = 1250000;
    localparam int unsigned FRAME_TICKS   = 1000000;
    localparam int unsigned ANGLE_MAX     = 180;

    localparam int unsigned WIDTH_W    = 17;
    localparam int unsigned PERIOD_W   = 21;
    localparam int unsigned DIVIDEND_W = 25;
    localparam int unsigned DIVISOR_W  = 17;
    localparam int unsigned ANGLE_W    = 8;

    typedef enum logic [2:0] {
        IDLE,
        MEASURE,
        MUL,
        DIV,
        DONE
    } state_e;

endpackage

// File: rtl/servo_pulse_decoder_if.sv
// Pulse input and decoded-result bundle between a pulse source/consumer and the decoder.
interface servo_pulse_decoder_if;
    import servo_pkg::*;

    logic               pwm_in;
    logic [ANGLE_W-1:0] angle;
    logic               angle_valid;
    logic               err_short;
    logic               err_long;
    logic               err_timeout;
    logic               busy;

    modport master (
        output pwm_in,
        input  angle, angle_valid, err_short, err_long, err_timeout, busy
    );

    modport slave (
        input  pwm_in,
        output angle, angle_valid, err_short, err_long, err_timeout, busy
    );
endinterface

// File: rtl/seq_div8.sv
// Restoring divider producing one quotient bit per cycle, MSB first; the first bit
// is resolved in the start cycle so done_o rises exactly 8 cycles after start_i.
module seq_div8
    import servo_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [DIVIDEND_W-1:0] dividend_i,
    input  logic [DIVISOR_W-1:0]  divisor_i,
    output logic                  done_o,
    output logic [ANGLE_W-1:0]    quotient_o
);

    localparam int unsigned CNT_W     = $clog2(ANGLE_W);
    localparam int unsigned LAST_STEP = ANGLE_W - 2;

    logic [DIVIDEND_W-1:0] rem_q, rem_d;
    logic [DIVIDEND_W-1:0] dsh_q, dsh_d;
    logic [ANGLE_W-1:0]    quot_q, quot_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  run_q, run_d;
    logic                  done_q, done_d;

    logic [DIVIDEND_W-1:0] src_rem_c;
    logic [DIVIDEND_W-1:0] src_dsh_c;
    logic                  ge_c;

    // Divisor is pre-aligned to the quotient MSB; quotient < 2**ANGLE_W is guaranteed by the caller.
    assign src_rem_c = start_i ? dividend_i : rem_q;
    assign src_dsh_c = start_i ? (DIVIDEND_W'(divisor_i) << (ANGLE_W - 1)) : dsh_q;
    assign ge_c      = (src_rem_c >= src_dsh_c);

    always_comb begin
        rem_d  = rem_q;
        dsh_d  = dsh_q;
        quot_d = quot_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        done_d = 1'b0;
        if (start_i || run_q) begin
            rem_d  = ge_c ? (src_rem_c - src_dsh_c) : src_rem_c;
            dsh_d  = src_dsh_c >> 1;
            quot_d = {(start_i ? (ANGLE_W - 1)'(0) : quot_q[ANGLE_W-2:0]), ge_c};
            cnt_d  = start_i ? CNT_W'(0) : (cnt_q + CNT_W'(1));
            run_d  = 1'b1;
            if (!start_i && (cnt_q == CNT_W'(LAST_STEP))) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            dsh_q  <= '0;
            quot_q <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            dsh_q  <= dsh_d;
            quot_q <= quot_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    assign done_o     = done_q;
    assign quotient_o = quot_q;

endmodule

// File: rtl/servo_pulse_decoder.sv
// Measures servo pulse high width in clk cycles and converts it to a 0..180 angle,
// flagging short, long and missing pulses.
module servo_pulse_decoder
    import servo_pkg::*;
#(
    parameter int unsigned MIN_WIDTH  = DEF_MIN_WIDTH,
    parameter int unsigned MAX_WIDTH  = DEF_MAX_WIDTH,
    parameter int unsigned TIMEOUT    = DEF_TIMEOUT,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    servo_pulse_decoder_if.slave bus
);

    localparam logic [WIDTH_W-1:0]   W_MIN   = WIDTH_W'(MIN_WIDTH);
    localparam logic [WIDTH_W-1:0]   W_MAX   = WIDTH_W'(MAX_WIDTH);
    localparam logic [WIDTH_W-1:0]   W_SAT   = WIDTH_W'(MAX_WIDTH + 1);
    localparam logic [PERIOD_W-1:0]  P_TO    = PERIOD_W'(TIMEOUT);
    localparam logic [DIVISOR_W-1:0] DIVISOR = DIVISOR_W'(MAX_WIDTH - MIN_WIDTH);

    state_e state_q, state_d;

    logic [1:0]          sync_q;
    logic [1:0]          fill_q;
    logic                prev_q;
    logic                armed_q;
    logic [WIDTH_W-1:0]  width_q, width_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic                pend_short_q, pend_short_d;
    logic                pend_long_q, pend_long_d;

    logic [ANGLE_W-1:0]  angle_q, angle_d;
    logic                valid_q, valid_d;
    logic                short_q, short_d;
    logic                long_q, long_d;
    logic                timeout_q, timeout_d;
    logic                busy_q, busy_d;

    logic                  level_c, lead_c, trail_c, timeout_hit_c;
    logic                  div_start_c, div_done;
    logic [ANGLE_W-1:0]    quotient;
    logic [WIDTH_W-1:0]    w_c;
    logic [DIVIDEND_W-1:0] dividend_c;

    // Arming waits until the synchronizer holds real samples and the line is seen idle,
    // so a pulse already high at reset release is never measured.
    assign level_c = sync_q[1] ^ ACTIVE_LOW;
    assign lead_c  = armed_q & level_c & ~prev_q;
    assign trail_c = prev_q & ~level_c;

    always_comb begin
        width_d = width_q;
        if (lead_c) begin
            width_d = WIDTH_W'(1);
        end else if (level_c && (width_q < W_SAT)) begin
            width_d = width_q + WIDTH_W'(1);
        end
        period_d = lead_c ? '0 : ((period_q < P_TO) ? (period_q + PERIOD_W'(1)) : period_q);
    end

    assign timeout_hit_c = (period_d == P_TO) && (period_q != P_TO);

    assign w_c        = (width_q < W_MIN) ? W_MIN : ((width_q > W_MAX) ? W_MAX : width_q);
    assign dividend_c = DIVIDEND_W'(w_c - W_MIN) * DIVIDEND_W'(ANGLE_MAX);

    seq_div8 u_div (
        .clk        (clk),
        .rst_n      (reset),
        .start_i    (div_start_c),
        .dividend_i (dividend_c),
        .divisor_i  (DIVISOR),
        .done_o     (div_done),
        .quotient_o (quotient)
    );

    // Results land on the DIV->DONE edge so they are visible during DONE, and win over a timeout.
    always_comb begin
        state_d      = state_q;
        div_start_c  = 1'b0;
        pend_short_d = pend_short_q;
        pend_long_d  = pend_long_q;
        angle_d      = angle_q;
        valid_d      = 1'b0;
        short_d      = short_q;
        long_d       = long_q;
        timeout_d    = timeout_q | timeout_hit_c;
        unique case (state_q)
            IDLE:    if (lead_c) state_d = MEASURE;
            MEASURE: if (trail_c) state_d = MUL;
            MUL: begin
                div_start_c  = 1'b1;
                pend_short_d = (width_q < W_MIN);
                pend_long_d  = (width_q > W_MAX);
                state_d      = DIV;
            end
            DIV: begin
                if (div_done) begin
                    angle_d   = quotient;
                    short_d   = pend_short_q;
                    long_d    = pend_long_q;
                    timeout_d = 1'b0;
                    valid_d   = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            sync_q       <= '0;
            fill_q       <= '0;
            prev_q       <= 1'b0;
            armed_q      <= 1'b0;
            width_q      <= '0;
            period_q     <= '0;
            pend_short_q <= 1'b0;
            pend_long_q  <= 1'b0;
            angle_q      <= '0;
            valid_q      <= 1'b0;
            short_q      <= 1'b0;
            long_q       <= 1'b0;
            timeout_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_q       <= {sync_q[0], bus.pwm_in};
            fill_q       <= (fill_q == 2'd2) ? fill_q : (fill_q + 2'd1);
            prev_q       <= level_c;
            armed_q      <= armed_q | ((fill_q == 2'd2) & ~level_c);
            width_q      <= width_d;
            period_q     <= period_d;
            pend_short_q <= pend_short_d;
            pend_long_q  <= pend_long_d;
            angle_q      <= angle_d;
            valid_q      <= valid_d;
            short_q      <= short_d;
            long_q       <= long_d;
            timeout_q    <= timeout_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.angle       = angle_q;
    assign bus.angle_valid = valid_q;
    assign bus.err_short   = short_q;
    assign bus.err_long    = long_q;
    assign bus.err_timeout = timeout_q;
    assign bus.busy        = busy_q;

endmodule
